// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store: data wins, a burst
// counter guarantees fetch progress. Define MEM_ARB_TIMEOUT_EN to add a watchdog abort.
module mem_port_arbiter #(
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  state_t     state, state_nxt;
  mreq_t      cur;
  logic       own_dm;
  logic [3:0] burst_cnt;
  logic       dm_pend, grant_dm, grant_if, fin, tmo;

  assign dm_pend   = dm_read | dm_write;
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_pend & ~dm_valid;
  assign mem_we    = cur.we;
  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // fin marks a real completion; reaching RESP without it is a watchdog abort
  always_comb begin
    state_nxt = state;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (dm_pend && (!if_req || burst_cnt < BURST_MAX)) begin
          grant_dm  = 1'b1;
          state_nxt = REQ;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ready && mem_done) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end else if (tmo)       state_nxt = RESP;
        else if (mem_ready)     state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end else if (tmo)       state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      own_dm    <= 1'b0;
      burst_cnt <= '0;
      mem_req   <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (grant_dm || grant_if) begin
        own_dm    <= grant_dm;
        mem_req   <= 1'b1;
        cur.we    <= grant_dm & dm_write;
        cur.addr  <= grant_dm ? dm_addr : if_addr;
        cur.wdata <= grant_dm ? dm_wdata : '0;
        burst_cnt <= (grant_dm && if_req) ? burst_cnt + 4'd1 : 4'd0;
      end
      if (state == REQ && (mem_ready || state_nxt == RESP)) mem_req <= 1'b0;
      if (state_nxt == RESP) begin
        if (own_dm) begin
          dm_valid <= 1'b1;
          dm_rdata <= fin ? mem_rdata : '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= fin ? mem_rdata : '0;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;

  // Held at zero in IDLE so every transaction starts counting from REQ entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      arb_err <= (state_nxt == RESP) && !fin;
      if (state == IDLE)                    tmo_cnt <= '0;
      else if (state == REQ || state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
  assign tmo = (state == REQ || state == WAIT) && (tmo_cnt >= TMO_LAST);
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (read-only) and the MEM stage (load/store, driven by the memread/memwrite control bits).
- One transaction outstanding at a time. Each requester holds its request until it receives a one-cycle valid pulse; the stall outputs freeze the pipeline meanwhile.
- Data accesses have priority. A burst counter guarantees fetch forward progress.

Parameters:
- DATA_BURST_MAX, 4: max consecutive data grants while if_req is pending; the next grant is forced to fetch. Range 1..15.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request; held until if_valid.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched word; meaningful only while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req && !if_valid (combinational).
- dm_read  in  1  load request.
- dm_write  in  1  store request.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; meaningful only while dm_valid is high.
- dm_valid  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  (dm_read||dm_write) && !dm_valid (combinational).
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1 = write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_done  in  1  transaction complete; mem_rdata valid this cycle.
- mem_rdata  in  32  memory read data.
- arb_err  out  1  timeout pulse (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, burst counter 0.
  - mem_req, mem_we, mem_addr, mem_wdata, if_valid, dm_valid, if_rdata, dm_rdata and arb_err are all 0.
  - Any outstanding transaction is abandoned; the memory is reset by the same rst_n.
- State machine: IDLE -> REQ -> WAIT -> RESP -> IDLE. The owner register (IF/DM) is set on grant.
- IDLE:
  - No request pending: stay in IDLE.
  - Data request pending and (no if_req, or counter < DATA_BURST_MAX): grant DM; counter increments if if_req is pending, otherwise clears to 0.
  - if_req pending and (no data request, or counter == DATA_BURST_MAX): grant IF; counter clears to 0.
  - On grant, register mem_addr/mem_we/mem_wdata from the owner. Fetch: mem_we=0, mem_wdata=0. Data: mem_we=dm_write.
  - dm_read && dm_write both high: treated as a write.
  - Next state is REQ.
- REQ:
  - mem_req=1, with address and data held.
  - If mem_ready=1 in this cycle, mem_req drops next cycle.
    - mem_done=1 in the same cycle: go to RESP.
    - Otherwise: go to WAIT.
  - mem_done without mem_ready is ignored.
- WAIT:
  - mem_req=0.
  - On mem_done: capture mem_rdata into the owner's rdata register and go to RESP.
  - For writes, rdata is captured but meaningless.
- RESP:
  - The owner's valid output is high for exactly this cycle.
  - All requests are ignored this cycle, so the still-asserted old request is not re-issued.
  - Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle 0: mem_req high at cycle 1.
  - With mem_ready at 1 and mem_done at cycle d (d>=1): valid at cycle d+1.
  - Minimum is 3 cycles request-to-valid, with a 1-cycle IDLE gap before the next grant.
- rdata registers hold their last captured value. They are not cleared after valid.
- A requester deasserting its request after grant does not cancel the transaction. It completes and the valid pulse is still produced.
- Stall outputs are purely combinational, so stall falls in the same cycle valid rises.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in REQ/WAIT and clears on entry to REQ.
  - If TIMEOUT_CYCLES elapse without mem_done, go to RESP with the owner's valid=1, rdata=0, and arb_err=1 for that cycle.
  - The memory must tolerate the abort; a late mem_done is ignored in IDLE.
- Undefined: no counter; arb_err is tied to 0; a hung memory stalls forever.

Test Plan:
1. Reset mid-WAIT (rst_n low 2 cycles during a fetch) -> all outputs 0 immediately; no valid pulse after release; next if_req is serviced normally.
2. if_req with if_addr=0x0000_0010, mem_ready at 1, mem_done at 3 with rdata=0x0050_0093 -> mem_req high cycle 1 only, mem_addr=0x10, if_valid at 4 with if_rdata=0x0050_0093, if_stall 1 for cycles 0..3.
3. if_req and dm_write (addr 0x100, wdata 0xDEAD_BEEF) both raised at cycle 0 -> DM granted first with mem_we=1 and mem_wdata=0xDEAD_BEEF; IF granted after the DM RESP.
4. Continuous dm_read plus continuous if_req with DATA_BURST_MAX=4 -> grant order DM,DM,DM,DM,IF, then repeats; never more than 4 consecutive DM grants.
5. Zero-wait memory (mem_ready and mem_done both in cycle 1) -> valid at cycle 2; the request still high in the RESP cycle is not re-issued (exactly one mem_req per transaction).
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_done never arrives -> owner valid and arb_err pulse 8 cycles after mem_req, rdata=0, state returns to IDLE.
